// File: rtl/alarm_set_multi.sv
// Multi-channel BCD alarm editor: edits a working copy of one channel
// and commits it atomically when edit mode is left.
module alarm_set_multi #(
   parameter int                      NUM_DIGITS = 4,
   parameter int                      NUM_CH     = 4,
   parameter int                      CH_W       = 2,
   parameter logic [4*NUM_DIGITS-1:0] DIGIT_MAX  = 16'h5959
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             edit_en,
   input  logic [CH_W-1:0]                  ch_sel,
   input  logic                             push_u,
   input  logic                             push_d,
   input  logic                             push_l,
   input  logic                             push_r,
   output logic [NUM_DIGITS-1:0]            sel,
   output logic [4*NUM_DIGITS-1:0]          edit_value,
   output logic [NUM_CH*4*NUM_DIGITS-1:0]   alarm_flat,
   output logic [NUM_CH-1:0]                armed,
   output logic                             commit,
   output logic                             editing
);

   localparam int DW    = 4 * NUM_DIGITS;
   localparam int CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CUR_W-1:0] CUR_MAX = CUR_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT, S_COMMIT} state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [CH_W-1:0]         r_ch;
   logic [CUR_W-1:0]        r_cur;
   logic [NUM_DIGITS-1:0]   r_sel;
   logic [DW-1:0]           r_edit;
   logic [NUM_CH*DW-1:0]    r_alarm;
   logic [NUM_CH-1:0]       r_armed;
   logic                    r_commit;
   logic                    r_editing;

   logic [DW-1:0]           w_load_val;
   logic [DW-1:0]           w_new_edit;
   logic [CUR_W-1:0]        w_new_cur;

   function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] mx);
      return (d >= mx) ? 4'd0 : d + 4'd1;
   endfunction

   function automatic logic [3:0] digit_dec(input logic [3:0] d, input logic [3:0] mx);
      return (d == 4'd0) ? mx : d - 4'd1;
   endfunction

   function automatic logic [CUR_W-1:0] cur_left(input logic [CUR_W-1:0] c);
      return (c == CUR_MAX) ? '0 : c + CUR_W'(1);
   endfunction

   function automatic logic [CUR_W-1:0] cur_right(input logic [CUR_W-1:0] c);
      return (c == '0) ? CUR_MAX : c - CUR_W'(1);
   endfunction

   function automatic logic [NUM_DIGITS-1:0] onehot(input logic [CUR_W-1:0] c);
      logic [NUM_DIGITS-1:0] o;
      o = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         o[i] = (c == CUR_W'(i));
      end
      return o;
   endfunction

   // Out-of-range channel requests collapse onto the last real channel
   function automatic logic [CH_W-1:0] clamp_ch(input logic [CH_W-1:0] ch);
      if (int'(ch) >= NUM_CH) return CH_W'(NUM_CH - 1);
      return ch;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (edit_en) w_next = S_LOAD;
         S_LOAD:   w_next = S_EDIT;
         S_EDIT:   if (!edit_en) w_next = S_COMMIT;
         S_COMMIT: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Digit edit uses the pre-move cursor; the move is computed alongside
   always_comb begin
      w_load_val = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (r_ch == CH_W'(c)) w_load_val = r_alarm[c*DW +: DW];
      end
      w_new_edit = r_edit;
      if (push_u != push_d) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_cur == CUR_W'(i)) begin
               w_new_edit[4*i +: 4] = push_u ? digit_inc(r_edit[4*i +: 4], DIGIT_MAX[4*i +: 4])
                                             : digit_dec(r_edit[4*i +: 4], DIGIT_MAX[4*i +: 4]);
            end
         end
      end
      w_new_cur = r_cur;
      if (push_l && !push_r)      w_new_cur = cur_left(r_cur);
      else if (push_r && !push_l) w_new_cur = cur_right(r_cur);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ch      <= '0;
         r_cur     <= '0;
         r_sel     <= '0;
         r_edit    <= '0;
         r_alarm   <= '0;
         r_armed   <= '0;
         r_commit  <= 1'b0;
         r_editing <= 1'b0;
      end else begin
         r_commit  <= 1'b0;
         r_editing <= (w_next == S_LOAD) || (w_next == S_EDIT);
         case (r_state)
            S_IDLE: begin
               r_sel <= '0;
               if (edit_en) r_ch <= clamp_ch(ch_sel);
            end
            S_LOAD: begin
               r_edit <= w_load_val;
               r_cur  <= CUR_MAX;
               r_sel  <= onehot(CUR_MAX);
            end
            S_EDIT: begin
               r_edit <= w_new_edit;
               r_cur  <= w_new_cur;
               r_sel  <= onehot(w_new_cur);
            end
            S_COMMIT: begin
               for (int c = 0; c < NUM_CH; c++) begin
                  if (r_ch == CH_W'(c)) begin
                     r_alarm[c*DW +: DW] <= r_edit;
                     r_armed[c]          <= |r_edit;
                  end
               end
               r_commit <= 1'b1;
               r_sel    <= '0;
            end
            default: r_sel <= '0;
         endcase
      end
   end

   assign sel        = r_sel;
   assign edit_value = r_edit;
   assign alarm_flat = r_alarm;
   assign armed      = r_armed;
   assign commit     = r_commit;
   assign editing    = r_editing;

endmodule

// File: tb/tb_alarm_set_multi.sv
// Directed bench for alarm_set_multi with a commit scoreboard and digit-range invariant.
module tb_alarm_set_multi;

   localparam int NUM_DIGITS = 4;
   localparam int NUM_CH     = 4;
   localparam int CH_W       = 2;
   localparam logic [15:0] DMAX = 16'h5959;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        edit_en, push_u, push_d, push_l, push_r;
   logic [1:0]  ch_sel;
   logic [3:0]  sel;
   logic [15:0] edit_value;
   logic [63:0] alarm_flat;
   logic [3:0]  armed;
   logic        commit, editing;

   typedef struct {
      logic [63:0] alarm;
      logic [3:0]  armed;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   checks = 0;
   int   errors = 0;
   int   n_commit = 0;
   logic [63:0] exp_alarm;
   logic [3:0]  exp_armed;

   alarm_set_multi #(
      .NUM_DIGITS(NUM_DIGITS), .NUM_CH(NUM_CH), .CH_W(CH_W), .DIGIT_MAX(DMAX)
   ) dut (
      .clk(clk), .reset_n(reset_n), .edit_en(edit_en), .ch_sel(ch_sel),
      .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r),
      .sel(sel), .edit_value(edit_value), .alarm_flat(alarm_flat),
      .armed(armed), .commit(commit), .editing(editing)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic digits_ok(input logic [15:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (v[4*i +: 4] > DMAX[4*i +: 4]) ok = 1'b0;
      end
      return ok;
   endfunction

   // Scoreboard consumer and stored-digit invariant
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         logic inv;
         inv = digits_ok(edit_value);
         for (int c = 0; c < NUM_CH; c++) inv = inv & digits_ok(alarm_flat[16*c +: 16]);
         check("digit_range", 64'(inv), 64'(1));
         if (commit === 1'b1) begin
            n_commit++;
            if (sb.size() == 0) begin
               check("unexpected_commit", 64'(1), 64'(0));
            end else begin
               m_e = sb.pop_front();
               check("sb_alarm_flat", alarm_flat, m_e.alarm);
               check("sb_armed", 64'(armed), 64'(m_e.armed));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic u, input logic d, input logic l, input logic r);
      push_u = u; push_d = d; push_l = l; push_r = r;
      step();
      push_u = 0; push_d = 0; push_l = 0; push_r = 0;
   endtask

   task automatic enter(input logic [1:0] ch);
      ch_sel  = ch;
      edit_en = 1'b1;
      step();
      step();
   endtask

   task automatic leave(input logic [15:0] ch_val, input int ch, input logic u);
      edit_en = 1'b0;
      exp_alarm[16*ch +: 16] = ch_val;
      exp_armed[ch] = (ch_val != 16'h0);
      sb.push_back('{alarm: exp_alarm, armed: exp_armed});
      push_u = u;
      step();
      push_u = 1'b0;
      step();
      check("commit_pulse", 64'(commit), 64'(1));
      step();
      check("commit_drop", 64'(commit), 64'(0));
      check("sel_idle", 64'(sel), 64'(0));
      check("editing_idle", 64'(editing), 64'(0));
   endtask

   initial begin
      reset_n = 1'b0; edit_en = 0; ch_sel = 0;
      push_u = 0; push_d = 0; push_l = 0; push_r = 0;
      exp_alarm = '0; exp_armed = '0;
      step(); step();
      check("rst_sel", 64'(sel), 64'(0));
      check("rst_edit", 64'(edit_value), 64'(0));
      check("rst_alarm", alarm_flat, 64'(0));
      check("rst_armed", 64'(armed), 64'(0));
      check("rst_commit", 64'(commit), 64'(0));
      check("rst_editing", 64'(editing), 64'(0));
      reset_n = 1'b1;
      repeat (10) step();
      check("idle_sel", 64'(sel), 64'(0));
      check("idle_alarm", alarm_flat, 64'(0));
      check("idle_armed", 64'(armed), 64'(0));

      // Basic edit of channel 2
      enter(2'd2);
      check("ld_sel", 64'(sel), 64'(4'b1000));
      check("ld_editing", 64'(editing), 64'(1));
      check("ld_value", 64'(edit_value), 64'(16'h0000));
      repeat (3) push(1, 0, 0, 0);
      push(0, 0, 0, 1);
      check("r_sel", 64'(sel), 64'(4'b0100));
      repeat (2) push(0, 1, 0, 0);
      check("ch2_value", 64'(edit_value), 64'(16'h3800));
      leave(16'h3800, 2, 1'b0);
      check("ch2_alarm", alarm_flat, 64'h0000_3800_0000_0000);
      check("ch2_armed", 64'(armed), 64'(4'b0100));
      check("hold_value", 64'(edit_value), 64'(16'h3800));

      // Wrap limits on channel 0
      enter(2'd0);
      repeat (5) push(1, 0, 0, 0);
      check("msd_max", 64'(edit_value), 64'(16'h5000));
      push(1, 0, 0, 0);
      check("msd_wrap", 64'(edit_value), 64'(16'h0000));
      push(0, 0, 0, 1);
      push(0, 1, 0, 0);
      check("d2_wrap_dn", 64'(edit_value), 64'(16'h0900));
      push(0, 0, 1, 0);
      check("l_back", 64'(sel), 64'(4'b1000));
      push(0, 0, 1, 0);
      check("l_wrap", 64'(sel), 64'(4'b0001));
      leave(16'h0900, 0, 1'b0);
      check("ch0_armed", 64'(armed), 64'(4'b0101));

      // Simultaneous pushes on channel 3, ch_sel changed mid-edit
      enter(2'd3);
      ch_sel = 2'd1;
      push(1, 0, 1, 0);
      check("ul_value", 64'(edit_value), 64'(16'h1000));
      check("ul_sel", 64'(sel), 64'(4'b0001));
      push(1, 1, 0, 0);
      check("ud_value", 64'(edit_value), 64'(16'h1000));
      push(0, 0, 1, 1);
      check("lr_sel", 64'(sel), 64'(4'b0001));
      leave(16'h1001, 3, 1'b1);
      check("ch3_alarm", alarm_flat, 64'h1001_3800_0000_0900);
      check("exit_push_value", 64'(edit_value), 64'(16'h1001));

      // Re-edit channel 2 down to zero; push during LOAD is ignored
      ch_sel = 2'd2; edit_en = 1'b1;
      step();
      push_u = 1'b1;
      step();
      push_u = 1'b0;
      check("reload_value", 64'(edit_value), 64'(16'h3800));
      check("reload_sel", 64'(sel), 64'(4'b1000));
      repeat (3) push(0, 1, 0, 0);
      push(0, 0, 0, 1);
      repeat (2) push(1, 0, 0, 0);
      check("zero_value", 64'(edit_value), 64'(16'h0000));
      leave(16'h0000, 2, 1'b0);
      check("ch2_cleared", alarm_flat, 64'h1001_0000_0000_0900);
      check("ch2_disarmed", 64'(armed), 64'(4'b1001));

      // Reset in the middle of an edit on channel 1
      enter(2'd1);
      repeat (2) push(1, 0, 0, 0);
      check("pre_rst_value", 64'(edit_value), 64'(16'h2000));
      #2 reset_n = 1'b0;
      #1;
      exp_alarm = '0; exp_armed = '0;
      check("mid_rst_alarm", alarm_flat, 64'(0));
      check("mid_rst_armed", 64'(armed), 64'(0));
      check("mid_rst_edit", 64'(edit_value), 64'(0));
      check("mid_rst_editing", 64'(editing), 64'(0));
      edit_en = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step(); step();
      check("post_rst_commit", 64'(commit), 64'(0));
      check("post_rst_sel", 64'(sel), 64'(0));

      // Single-cycle edit_en pulse still walks LOAD/EDIT/COMMIT
      ch_sel = 2'd1; edit_en = 1'b1;
      sb.push_back('{alarm: exp_alarm, armed: exp_armed});
      step();
      edit_en = 1'b0;
      step();
      check("pulse_editing", 64'(editing), 64'(1));
      check("pulse_value", 64'(edit_value), 64'(0));
      step(); step();
      check("pulse_commit", 64'(commit), 64'(1));
      check("pulse_alarm", alarm_flat, 64'(0));
      step();
      check("pulse_commit_drop", 64'(commit), 64'(0));

      repeat (3) step();
      check("sb_drained", 64'(sb.size()), 64'(0));
      check("commit_count", 64'(n_commit), 64'(5));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_set_multi.md
Name: alarm_set_multi

Overview:
- Parametrised successor to the single-alarm digit editor.
- Holds NUM_CH independent BCD alarm registers of NUM_DIGITS digits each, with a per-digit upper limit (e.g. MM:SS, tens digits 0-5).
- Edits a working copy of the selected channel while edit_en is high, then commits it atomically on edit_en fall with a one-cycle commit pulse and per-channel armed flags.
- Sits between the debounced push-button/switch inputs and the alarm comparator / 7-segment display mux.

Parameters:
- NUM_DIGITS, 4, digits per alarm. Digit NUM_DIGITS-1 is leftmost.
- NUM_CH, 4, number of alarm channels.
- CH_W, 2, channel index width. Must satisfy 2**CH_W >= NUM_CH.
- DIGIT_MAX, 16'h5959, packed 4-bit per-digit maximum. Field i limits digit i. Each field must be in 1..9.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- edit_en  input  1  edit-mode switch, level; synchronous to clk
- ch_sel  input  CH_W  channel to edit; sampled only on edit entry
- push_u  input  1  increment cursor digit; single-cycle pulse
- push_d  input  1  decrement cursor digit; single-cycle pulse
- push_l  input  1  move cursor left; single-cycle pulse
- push_r  input  1  move cursor right; single-cycle pulse
- sel  output  NUM_DIGITS  one-hot cursor; all-zero when not editing
- edit_value  output  4*NUM_DIGITS  working copy, BCD
- alarm_flat  output  NUM_CH*4*NUM_DIGITS  committed alarms; channel c at [c*4*NUM_DIGITS +: 4*NUM_DIGITS]
- armed  output  NUM_CH  channel holds a nonzero committed value
- commit  output  1  one-cycle pulse when a channel is written
- editing  output  1  high in LOAD or EDIT

Behaviour:
- Reset (async, reset_n=0): state=IDLE; sel=0, edit_value=0, alarm_flat=0, armed=0, commit=0, editing=0, cursor index=0, latched channel=0.
- FSM states: IDLE, LOAD, EDIT, COMMIT.
- IDLE:
  - sel=0.
  - On edit_en=1: latch ch_sel into ch_q and go to LOAD.
  - If ch_sel >= NUM_CH: latch NUM_CH-1 instead.
- LOAD (1 cycle):
  - edit_value <= alarm_flat slice for ch_q.
  - Cursor index <= NUM_DIGITS-1; sel <= one-hot MSD.
  - Next state EDIT, even if edit_en has dropped.
  - Push inputs are ignored in LOAD.
- EDIT:
  - push_u: cursor digit wraps DIGIT_MAX[i] -> 0, else +1.
  - push_d: cursor digit wraps 0 -> DIGIT_MAX[i], else -1.
  - push_u and push_d together: no change.
  - push_l: cursor index +1, wrapping NUM_DIGITS-1 -> 0.
  - push_r: cursor index -1, wrapping 0 -> NUM_DIGITS-1.
  - push_l and push_r together: no move.
  - Digit change and cursor move in the same cycle: the digit change applies to the pre-move cursor position; both take effect.
  - ch_sel changes are ignored.
  - edit_en=0 sampled: go to COMMIT. Pushes in that same cycle are still applied.
- COMMIT (1 cycle):
  - alarm_flat slice ch_q <= edit_value.
  - armed[ch_q] <= (edit_value != 0).
  - commit=1 for exactly this cycle. All other channels are unchanged.
  - Next state is IDLE; sel returns to 0 there.
  - edit_en=1 during COMMIT is not acted on until IDLE (min 1 IDLE cycle between sessions).
- Latency: commit pulse and new alarm_flat both become visible on the 2nd rising edge after edit_en falls (edge 1 samples edit_en low, edge 2 writes). edit_value becomes valid 2 edges after edit_en rises.
- edit_value holds its last working copy in IDLE; there is no clear on exit.
- Reset mid-EDIT: session is discarded with no commit; all channels are zeroed.
- Stored digits never exceed DIGIT_MAX (invariant; asserted in bench).
- All outputs are registered.

Test Plan:
- Reset then idle 10 cycles -> sel=0, alarm_flat=0, armed=0, commit never 1.
- Edit ch 2: edit_en=1, 3x push_u, push_r, 2x push_d, edit_en=0 -> alarm ch2=16'h3800, armed=4'b0100, commit single pulse, ch0/1/3 still 0.
- Wrap limits on defaults: at MSD (max 5), 6x push_u -> digit returns 0. On digit 2 (max 9), push_d from 0 -> 9. push_l at MSD -> sel=4'b0001.
- Simultaneous: push_u+push_l same cycle at MSD=0 -> MSD=1 and cursor on digit 0. push_u+push_d together -> value unchanged.
- Re-edit ch 2 and set all digits to 0, then commit -> armed[2]=0, alarm ch2=0, commit pulse.
- Assert reset_n=0 mid-EDIT after setting ch1 digits -> no commit pulse, alarm_flat=0, state IDLE after release. Also pulse edit_en for 1 cycle -> LOAD -> EDIT -> COMMIT writes the unchanged copy.
